// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by if_stage and its fetch buffer.
package if_stage_pkg;

    localparam int REG_W  = 64;
    localparam int INST_W = 32;

    localparam logic [REG_W-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT      = 2'd1,
        S_WAIT_KILL = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [REG_W-1:0]  addr;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO holding fetched {inst, addr} pairs.
// Flush wins over push and pop; push+pop while non-empty keeps count.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  data_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o,
    output logic          head_valid_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    // Qualify requests so the buffer never over- or under-flows.
    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    end

    // Storage write; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers and occupancy; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count_o      = cnt_q;
    assign head_o       = mem_q[rd_q];
    assign head_valid_o = (cnt_q != '0);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single outstanding imem request, fetch buffer.
// Redirects flush wrong-path state; responses in flight are killed.
module if_stage
    import if_stage_pkg::*;
#(
    parameter  logic [REG_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter  int               FB_DEPTH = 2,
    localparam int               CW       = $clog2(FB_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [REG_W-1:0]  imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redir_valid,
    input  logic [REG_W-1:0]  redir_target,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [REG_W-1:0]  inst_addr,
    input  logic              id_ready
);

    if_state_e        state_q;
    if_state_e        state_d;
    logic [REG_W-1:0] pc_q;
    logic [REG_W-1:0] pc_d;
    logic [REG_W-1:0] req_addr_q;
    logic [REG_W-1:0] req_addr_d;

    logic             push;
    logic             pop;
    logic             issue;
    logic             slot_free;
    logic [CW-1:0]    fb_count;
    logic [CW-1:0]    occ_next;
    logic             fb_valid;
    fetch_entry_t     fb_head;
    fetch_entry_t     fb_in;

    // Handshake, credit check and next-state/PC selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;

        inst_valid = fb_valid && !redir_valid && !rst;
        pop        = inst_valid && id_ready;
        push       = (state_q == S_WAIT) && imem_ack && !redir_valid;
        occ_next   = fb_count + CW'(push) - CW'(pop);
        slot_free  = (state_q == S_IDLE) || imem_ack;
        issue      = !rst && !redir_valid && slot_free
                     && (occ_next < CW'(FB_DEPTH));

        if (redir_valid) begin
            pc_d = redir_target & ~64'h3;
            if (state_q != S_IDLE && !imem_ack) begin
                state_d = S_WAIT_KILL;
            end else begin
                state_d = S_IDLE;
            end
        end else if (issue) begin
            pc_d       = pc_q + 64'd4;
            req_addr_d = pc_q;
            state_d    = S_WAIT;
        end else if (state_q != S_IDLE && imem_ack) begin
            state_d = S_IDLE;
        end

        imem_req  = issue;
        imem_addr = issue ? pc_q : '0;
        inst      = rst ? '0 : fb_head.inst;
        inst_addr = rst ? '0 : fb_head.addr;
        fb_in     = '{inst: imem_rdata, addr: req_addr_q};
    end

    // Fetch control state, PC and address of the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FB_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redir_valid),
        .data_i       (fb_in),
        .count_o      (fb_count),
        .head_o       (fb_head),
        .head_valid_o (fb_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios with a latency-
// configurable memory model; monitor checks requests and delivered insts.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [63:0] redir_target;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        id_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_req_q[$];
    logic [63:0] exp_inst_q[$];

    int          lat     = 1;
    int          mem_cnt = 0;
    logic [63:0] mem_addr = '0;

    localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A1 = 64'h0000_0000_8000_0004;
    localparam logic [63:0] A2 = 64'h0000_0000_8000_0008;

    always #5 clk = ~clk;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_addr    (inst_addr),
        .id_ready     (id_ready)
    );

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: answers each request after 'lat' cycles with mdata(addr).
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mdata(mem_addr);
                end
            end
            @(negedge clk);
            if (imem_req) begin
                mem_addr = imem_addr;
                mem_cnt  = lat;
            end
        end
    end

    // Monitor: pops expectations when the DUT issues or delivers.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (imem_req && exp_req_q.size() > 0) begin
                e = exp_req_q.pop_front();
                check("req_addr", imem_addr, e);
            end
            if (inst_valid && id_ready && exp_inst_q.size() > 0) begin
                e = exp_inst_q.pop_front();
                check("inst_addr", inst_addr, e);
                check("inst", {32'h0, inst}, {32'h0, mdata(e)});
            end
        end
    end

    task automatic do_reset(input int n);
        step();
        rst         = 1'b1;
        redir_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_imem_req", {63'h0, imem_req}, 64'h0);
            check("rst_imem_addr", imem_addr, 64'h0);
            check("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
            check("rst_inst", {32'h0, inst}, 64'h0);
            check("rst_inst_addr", inst_addr, 64'h0);
            step();
        end
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int max);
        for (int i = 0; i < max; i++) begin
            if (exp_req_q.size() == 0 && exp_inst_q.size() == 0) break;
            step();
        end
        check({nm, "_req_left"}, 64'(exp_req_q.size()), 64'h0);
        check({nm, "_inst_left"}, 64'(exp_inst_q.size()), 64'h0);
        exp_req_q.delete();
        exp_inst_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst          = 1'b1;
        redir_valid  = 1'b0;
        redir_target = '0;
        id_ready     = 1'b0;

        // 1: reset then stream
        lat      = 1;
        id_ready = 1'b1;
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            exp_req_q.push_back(A0 + 64'(4 * i));
            exp_inst_q.push_back(A0 + 64'(4 * i));
        end
        @(negedge clk);
        check("t1_first_req", {63'h0, imem_req}, 64'h1);
        check("t1_c0_valid", {63'h0, inst_valid}, 64'h0);
        step();
        @(negedge clk);
        check("t1_c1_valid", {63'h0, inst_valid}, 64'h0);
        for (int k = 2; k < 10; k++) begin
            step();
            @(negedge clk);
            check("t1_stream_valid", {63'h0, inst_valid}, 64'h1);
        end
        wait_drain("t1", 5);

        // 2: backpressure
        lat      = 1;
        id_ready = 1'b0;
        do_reset(4);
        exp_req_q.push_back(A0);
        exp_req_q.push_back(A1);
        @(negedge clk);
        check("t2_req0", {63'h0, imem_req}, 64'h1);
        step();
        @(negedge clk);
        check("t2_req1", {63'h0, imem_req}, 64'h1);
        for (int k = 2; k < 8; k++) begin
            step();
            @(negedge clk);
            check("t2_no_req", {63'h0, imem_req}, 64'h0);
        end
        check("t2_full_valid", {63'h0, inst_valid}, 64'h1);
        check("t2_full_head", inst_addr, A0);
        step();
        exp_req_q.push_back(A2);
        exp_inst_q.push_back(A0);
        exp_inst_q.push_back(A1);
        exp_inst_q.push_back(A2);
        id_ready = 1'b1;
        wait_drain("t2", 12);

        // 3: redirect while a request is outstanding
        lat      = 3;
        id_ready = 1'b1;
        do_reset(4);
        exp_req_q.push_back(A0);
        exp_req_q.push_back(A1);
        exp_req_q.push_back(A2);
        exp_req_q.push_back(64'h8000_1000);
        exp_req_q.push_back(64'h8000_1004);
        exp_inst_q.push_back(A0);
        exp_inst_q.push_back(64'h8000_1000);
        exp_inst_q.push_back(64'h8000_1004);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == A2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("t3_saw_req_a2", {63'h0, found}, 64'h1);
        step();
        redir_valid  = 1'b1;
        redir_target = 64'h8000_1000;
        @(negedge clk);
        check("t3_redir_valid_low", {63'h0, inst_valid}, 64'h0);
        check("t3_redir_no_req", {63'h0, imem_req}, 64'h0);
        step();
        redir_valid = 1'b0;
        wait_drain("t3", 30);

        // 4: redirect coincident with ack and id_ready
        lat      = 1;
        id_ready = 1'b1;
        do_reset(4);
        exp_req_q.push_back(A0);
        exp_req_q.push_back(A1);
        exp_req_q.push_back(64'h8000_2000);
        exp_req_q.push_back(64'h8000_2004);
        exp_inst_q.push_back(64'h8000_2000);
        exp_inst_q.push_back(64'h8000_2004);
        step();
        step();
        redir_valid  = 1'b1;
        redir_target = 64'h8000_2000;
        @(negedge clk);
        check("t4_redir_valid_low", {63'h0, inst_valid}, 64'h0);
        check("t4_redir_no_req", {63'h0, imem_req}, 64'h0);
        step();
        redir_valid = 1'b0;
        @(negedge clk);
        check("t4_empty_after", {63'h0, inst_valid}, 64'h0);
        check("t4_req_target", {63'h0, imem_req}, 64'h1);
        wait_drain("t4", 10);

        // 5a: misaligned target
        lat      = 1;
        id_ready = 1'b1;
        do_reset(4);
        redir_valid  = 1'b1;
        redir_target = 64'h8000_0106;
        exp_req_q.push_back(64'h8000_0104);
        exp_inst_q.push_back(64'h8000_0104);
        @(negedge clk);
        check("t5_redir_no_req", {63'h0, imem_req}, 64'h0);
        step();
        redir_valid = 1'b0;
        @(negedge clk);
        check("t5_req_after", {63'h0, imem_req}, 64'h1);
        wait_drain("t5a", 10);

        // 5b: PC wraps past the top of the address space
        do_reset(4);
        redir_valid  = 1'b1;
        redir_target = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_req_q.push_back(64'h0);
        exp_req_q.push_back(64'h4);
        exp_inst_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_inst_q.push_back(64'h0);
        exp_inst_q.push_back(64'h4);
        step();
        redir_valid = 1'b0;
        wait_drain("t5b", 10);

        // 6: reset mid-operation; stale ack lands after reset
        lat      = 4;
        id_ready = 1'b0;
        do_reset(4);
        exp_req_q.push_back(A0);
        exp_req_q.push_back(A1);
        exp_req_q.push_back(A0);
        exp_inst_q.push_back(A0);
        repeat (5) step();
        @(negedge clk);
        check("t6_pre_valid", {63'h0, inst_valid}, 64'h1);
        check("t6_pre_head", inst_addr, A0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", {63'h0, inst_valid}, 64'h0);
        check("t6_rst_req", {63'h0, imem_req}, 64'h0);
        step();
        step();
        rst      = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        check("t6_stale_valid", {63'h0, inst_valid}, 64'h0);
        check("t6_req_reset_pc", {63'h0, imem_req}, 64'h1);
        step();
        @(negedge clk);
        check("t6_stale_ignored", {63'h0, inst_valid}, 64'h0);
        wait_drain("t6", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
